// File: rtl/stream_demux_if.sv
// stream_demux_if: one input stream routed to four output channels
interface stream_demux_if #(parameter int WIDTH = 8);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_demux.sv
// stream_demux: routes each accepted word into a one-entry holding register per channel
module stream_demux #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    stream_demux_if.slave       s,
    output logic                busy,
    output logic [7:0]          drained_cnt
);
    logic [3:0]       full_q, full_d, drain, load;
    logic [WIDTH-1:0] data_q [4];
    logic [7:0]       cnt_q, cnt_d;
    always_comb begin
        drain      = full_q & s.out_ready;
        s.in_ready = !rst && (!full_q[s.in_sel] || s.out_ready[s.in_sel]);
        load       = (s.in_valid && s.in_ready) ? (4'b0001 << s.in_sel) : 4'b0000;
        full_d     = (full_q & ~drain) | load;
        cnt_d      = cnt_q + 8'($countones(drain));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 4'b0000;
            cnt_q  <= 8'd0;
        end else begin
            full_q <= full_d;
            cnt_q  <= cnt_d;
        end
    end
    // data registers need no reset: they are only observed while full
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (load[k]) data_q[k] <= s.in_data;
    end
    for (genvar k = 0; k < 4; k++) begin : g_out
        assign s.out_data[k*WIDTH +: WIDTH] = data_q[k];
    end
    assign s.out_valid  = full_q;
    assign busy         = |full_q;
    assign drained_cnt  = cnt_q;
endmodule
